// File: rtl/membuf_sched.sv
// -----------------------------------------------------------------------------
// membuf_sched
//   Burst scheduler in front of a banked on-chip buffer. Two requesters share
//   the buffer one burst at a time:
//     - the loader, which reads/writes a single bank (mode 0, m0_* port)
//     - the PE array, which reads/writes all banks in lock-step (mode 1, m1_*)
//   Commands are only taken in IDLE. When both requesters ask in the same
//   cycle a round-robin pointer picks one. Loader commands naming a bank
//   outside 0..N_PE-1 are consumed and flagged on ld_err without any bank
//   activity.
//
// Ports
//   clk, rst                         clock, async active-low reset
//   ld_cmd_*  / pe_cmd_*             command handshakes (wr, bank, addr, len)
//   ld_wvalid/ld_wready, pe_w*       write-beat handshakes
//   ld_rvalid, pe_rvalid             read data valid, one cycle after r_en
//   ld_err                           one-cycle pulse for a bad loader bank
//   mode                             0 = loader path, 1 = PE broadcast path
//   m0_r_en/m0_w_en, m0_*_addr       one-hot loader bank enables and address
//   m1_r_en/m1_w_en, m1_*_addr       broadcast enables and address
//   busy, done                       burst active; one-cycle end-of-burst pulse
// -----------------------------------------------------------------------------
module membuf_sched #(
  parameter int N_PE     = 16,
  parameter int ADDR_RAM = 10,
  parameter int BANK_W   = 6
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ld_cmd_valid,
  output logic                ld_cmd_ready,
  input  logic                ld_cmd_wr,
  input  logic [BANK_W-1:0]   ld_cmd_bank,
  input  logic [ADDR_RAM-1:0] ld_cmd_addr,
  input  logic [7:0]          ld_cmd_len,
  input  logic                ld_wvalid,
  output logic                ld_wready,
  output logic                ld_rvalid,
  output logic                ld_err,

  input  logic                pe_cmd_valid,
  output logic                pe_cmd_ready,
  input  logic                pe_cmd_wr,
  input  logic [ADDR_RAM-1:0] pe_cmd_addr,
  input  logic [7:0]          pe_cmd_len,
  input  logic                pe_wvalid,
  output logic                pe_wready,
  output logic                pe_rvalid,

  output logic                mode,
  output logic [N_PE-1:0]     m0_r_en,
  output logic [N_PE-1:0]     m0_w_en,
  output logic [ADDR_RAM-1:0] m0_r_addr,
  output logic [ADDR_RAM-1:0] m0_w_addr,
  output logic [ADDR_RAM-1:0] m1_r_addr,
  output logic [ADDR_RAM-1:0] m1_w_addr,
  output logic                m1_r_en,
  output logic                m1_w_en,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_WR,
    S_LD_RD,
    S_PE_WR,
    S_PE_RD,
    S_DRAIN
  } state_t;

  state_t                r_state;
  logic                  r_mode;
  logic                  r_rr_pe;      // 1: PE wins the next tie
  logic [BANK_W-1:0]     r_bank;
  logic [ADDR_RAM-1:0]   r_addr;
  logic [8:0]            r_cnt;        // beats remaining, 1..256
  logic                  r_ld_rvalid;
  logic                  r_pe_rvalid;
  logic                  r_done;
  logic                  r_err;

  logic                  w_idle;
  logic                  w_grant_ld;
  logic                  w_grant_pe;
  logic                  w_bad_bank;
  logic                  w_ld_beat;
  logic                  w_pe_beat;
  logic                  w_last;
  logic [N_PE-1:0]       w_onehot;

  // The state register already sits at IDLE while reset is held, so the
  // readies are additionally gated by rst to stay low during reset.
  assign w_idle     = (r_state == S_IDLE) && rst;
  assign w_grant_ld = w_idle && ld_cmd_valid && (!pe_cmd_valid || !r_rr_pe);
  assign w_grant_pe = w_idle && pe_cmd_valid && (!ld_cmd_valid ||  r_rr_pe);
  assign w_bad_bank = int'(ld_cmd_bank) >= N_PE;
  assign w_ld_beat  = (r_state == S_LD_WR) && ld_wvalid;
  assign w_pe_beat  = (r_state == S_PE_WR) && pe_wvalid;
  assign w_last     = (r_cnt == 9'd1);
  assign w_onehot   = {{(N_PE-1){1'b0}}, 1'b1} << r_bank;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_rr_pe     <= 1'b0;
      r_bank      <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_ld_rvalid <= 1'b0;
      r_pe_rvalid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge register values regardless of statement order.
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      // Bank read latency is one cycle: valid follows each read issue.
      r_ld_rvalid <= (r_state == S_LD_RD);
      r_pe_rvalid <= (r_state == S_PE_RD);

      case (r_state)
        S_IDLE: begin
          if (w_grant_ld) begin
            r_rr_pe <= 1'b1;
            r_mode  <= 1'b0;
            if (w_bad_bank) begin
              r_err <= 1'b1;
            end else begin
              r_state <= ld_cmd_wr ? S_LD_WR : S_LD_RD;
              r_bank  <= ld_cmd_bank;
              r_addr  <= ld_cmd_addr;
              r_cnt   <= {1'b0, ld_cmd_len} + 9'd1;
            end
          end else if (w_grant_pe) begin
            r_rr_pe <= 1'b0;
            r_mode  <= 1'b1;
            r_state <= pe_cmd_wr ? S_PE_WR : S_PE_RD;
            r_addr  <= pe_cmd_addr;
            r_cnt   <= {1'b0, pe_cmd_len} + 9'd1;
          end
        end

        S_LD_WR, S_PE_WR: begin
          // A stalled beat leaves address and count untouched.
          if (w_ld_beat || w_pe_beat) begin
            r_addr <= r_addr + ADDR_RAM'(1);
            r_cnt  <= r_cnt - 9'd1;
            if (w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end

        S_LD_RD, S_PE_RD: begin
          r_addr <= r_addr + ADDR_RAM'(1);
          r_cnt  <= r_cnt - 9'd1;
          if (w_last) begin
            // One extra cycle lets the final read data come back before IDLE.
            r_state <= S_DRAIN;
            r_done  <= 1'b1;
          end
        end

        S_DRAIN: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ld_cmd_ready = w_idle;
  assign pe_cmd_ready = w_idle;
  assign ld_wready    = (r_state == S_LD_WR);
  assign pe_wready    = (r_state == S_PE_WR);
  assign ld_rvalid    = r_ld_rvalid;
  assign pe_rvalid    = r_pe_rvalid;
  assign ld_err       = r_err;
  assign mode         = r_mode;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;

  // Loader states only exist with mode 0 and PE states with mode 1, so
  // deriving enables from the state alone keeps each port silent in the
  // other mode.
  assign m0_w_en   = w_ld_beat ? w_onehot : '0;
  assign m0_r_en   = (r_state == S_LD_RD) ? w_onehot : '0;
  assign m1_w_en   = w_pe_beat;
  assign m1_r_en   = (r_state == S_PE_RD);
  assign m0_r_addr = r_addr;
  assign m0_w_addr = r_addr;
  assign m1_r_addr = r_addr;
  assign m1_w_addr = r_addr;

endmodule

// File: tb/tb_membuf_sched.sv
// -----------------------------------------------------------------------------
// tb_membuf_sched
//   Self-checking bench for membuf_sched. A burst-level reference model
//   (owner, direction, address, beats left, drain flag) predicts every output
//   each cycle; directed scenarios pin the model with hand-computed values,
//   then a randomized phase exercises arbitration, stalls, wrap and reset.
// -----------------------------------------------------------------------------
module tb_membuf_sched;

  localparam int N_PE = 16;
  localparam int AW   = 10;
  localparam int BW   = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            ld_cmd_valid, ld_cmd_ready, ld_cmd_wr;
  logic [BW-1:0]   ld_cmd_bank;
  logic [AW-1:0]   ld_cmd_addr;
  logic [7:0]      ld_cmd_len;
  logic            ld_wvalid, ld_wready, ld_rvalid, ld_err;
  logic            pe_cmd_valid, pe_cmd_ready, pe_cmd_wr;
  logic [AW-1:0]   pe_cmd_addr;
  logic [7:0]      pe_cmd_len;
  logic            pe_wvalid, pe_wready, pe_rvalid;
  logic            mode;
  logic [N_PE-1:0] m0_r_en, m0_w_en;
  logic [AW-1:0]   m0_r_addr, m0_w_addr, m1_r_addr, m1_w_addr;
  logic            m1_r_en, m1_w_en, busy, done;

  always #5 clk = ~clk;

  membuf_sched #(.N_PE(N_PE), .ADDR_RAM(AW), .BANK_W(BW)) dut (
    .clk(clk), .rst(rst),
    .ld_cmd_valid(ld_cmd_valid), .ld_cmd_ready(ld_cmd_ready), .ld_cmd_wr(ld_cmd_wr),
    .ld_cmd_bank(ld_cmd_bank), .ld_cmd_addr(ld_cmd_addr), .ld_cmd_len(ld_cmd_len),
    .ld_wvalid(ld_wvalid), .ld_wready(ld_wready), .ld_rvalid(ld_rvalid), .ld_err(ld_err),
    .pe_cmd_valid(pe_cmd_valid), .pe_cmd_ready(pe_cmd_ready), .pe_cmd_wr(pe_cmd_wr),
    .pe_cmd_addr(pe_cmd_addr), .pe_cmd_len(pe_cmd_len),
    .pe_wvalid(pe_wvalid), .pe_wready(pe_wready), .pe_rvalid(pe_rvalid),
    .mode(mode), .m0_r_en(m0_r_en), .m0_w_en(m0_w_en),
    .m0_r_addr(m0_r_addr), .m0_w_addr(m0_w_addr),
    .m1_r_addr(m1_r_addr), .m1_w_addr(m1_w_addr),
    .m1_r_en(m1_r_en), .m1_w_en(m1_w_en), .busy(busy), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one active burst at most, described by its owner,
  // direction, current address and beats still to go.
  // ---------------------------------------------------------------------------
  bit m_act, m_pe, m_wr, m_drain, m_mode, m_rr_pe;
  bit m_done, m_err, m_ldrv, m_perv;
  int m_addr, m_left, m_bank;

  task automatic model_reset();
    m_act = 0; m_pe = 0; m_wr = 0; m_drain = 0; m_mode = 0; m_rr_pe = 0;
    m_done = 0; m_err = 0; m_ldrv = 0; m_perv = 0;
    m_addr = 0; m_left = 0; m_bank = 0;
  endtask

  task automatic model_step();
    bit g_ld, g_pe;
    m_done = 0; m_err = 0; m_ldrv = 0; m_perv = 0;
    if (!m_act) begin
      g_ld = ld_cmd_valid && (!pe_cmd_valid || !m_rr_pe);
      g_pe = pe_cmd_valid && !g_ld;
      if (g_ld) begin
        m_rr_pe = 1; m_mode = 0;
        if (int'(ld_cmd_bank) >= N_PE) m_err = 1;
        else begin
          m_act = 1; m_pe = 0; m_wr = ld_cmd_wr; m_drain = 0;
          m_bank = int'(ld_cmd_bank); m_addr = int'(ld_cmd_addr);
          m_left = int'(ld_cmd_len) + 1;
        end
      end else if (g_pe) begin
        m_rr_pe = 0; m_mode = 1;
        m_act = 1; m_pe = 1; m_wr = pe_cmd_wr; m_drain = 0;
        m_addr = int'(pe_cmd_addr); m_left = int'(pe_cmd_len) + 1;
      end
    end else if (m_drain) begin
      m_act = 0;
    end else begin
      if (!m_wr) begin
        if (m_pe) m_perv = 1; else m_ldrv = 1;
      end
      if (!m_wr || (m_pe ? pe_wvalid : ld_wvalid)) begin
        m_addr = (m_addr + 1) % (1 << AW);
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          if (m_wr) m_act = 0; else m_drain = 1;
        end
      end
    end
  endtask

  // Event logs of actual DUT activity, used by the directed scenarios.
  int cyc = 0;
  int q_w0_en[$], q_w0_addr[$], q_w1_addr[$];
  int q_r1_addr[$], q_r1_cyc[$], q_perv_cyc[$], q_done_cyc[$];
  int n_done = 0, n_err = 0, n_en_any = 0;

  task automatic clear_logs();
    q_w0_en.delete(); q_w0_addr.delete(); q_w1_addr.delete();
    q_r1_addr.delete(); q_r1_cyc.delete(); q_perv_cyc.delete(); q_done_cyc.delete();
    n_done = 0; n_err = 0; n_en_any = 0;
  endtask

  // Compare process: outputs sampled on the falling edge, model advanced to
  // the state it predicts for the following rising edge.
  always @(negedge clk) begin
    bit ld_w, ld_r, pe_w, pe_r;
    int oh;
    cyc++;
    if (m0_w_en != 0) begin q_w0_en.push_back(int'(m0_w_en)); q_w0_addr.push_back(int'(m0_w_addr)); end
    if (m1_w_en) q_w1_addr.push_back(int'(m1_w_addr));
    if (m1_r_en) begin q_r1_addr.push_back(int'(m1_r_addr)); q_r1_cyc.push_back(cyc); end
    if (pe_rvalid) q_perv_cyc.push_back(cyc);
    if (done) begin n_done++; q_done_cyc.push_back(cyc); end
    if (ld_err) n_err++;
    if ((m0_w_en != 0) || (m0_r_en != 0) || m1_w_en || m1_r_en) n_en_any++;

    if (!rst) begin
      check("rst_busy",   32'(busy), 0);
      check("rst_mode",   32'(mode), 0);
      check("rst_ready",  32'({ld_cmd_ready, pe_cmd_ready, ld_wready, pe_wready}), 0);
      check("rst_valids", 32'({ld_rvalid, pe_rvalid, done, ld_err}), 0);
      check("rst_en",     32'({m0_r_en, m0_w_en, m1_r_en, m1_w_en}), 0);
      check("rst_addr",   32'({m0_r_addr, m0_w_addr, m1_r_addr}), 0);
      model_reset();
    end else begin
      ld_w = m_act && !m_drain && !m_pe &&  m_wr;
      ld_r = m_act && !m_drain && !m_pe && !m_wr;
      pe_w = m_act && !m_drain &&  m_pe &&  m_wr;
      pe_r = m_act && !m_drain &&  m_pe && !m_wr;
      oh   = 1 << m_bank;
      check("ld_cmd_ready", 32'(ld_cmd_ready), 32'(!m_act));
      check("pe_cmd_ready", 32'(pe_cmd_ready), 32'(!m_act));
      check("busy",         32'(busy),         32'(m_act));
      check("mode",         32'(mode),         32'(m_mode));
      check("done",         32'(done),         32'(m_done));
      check("ld_err",       32'(ld_err),       32'(m_err));
      check("ld_rvalid",    32'(ld_rvalid),    32'(m_ldrv));
      check("pe_rvalid",    32'(pe_rvalid),    32'(m_perv));
      check("ld_wready",    32'(ld_wready),    32'(ld_w));
      check("pe_wready",    32'(pe_wready),    32'(pe_w));
      check("m0_w_en",      32'(m0_w_en),      (ld_w && ld_wvalid) ? oh : 0);
      check("m0_r_en",      32'(m0_r_en),      ld_r ? oh : 0);
      check("m1_w_en",      32'(m1_w_en),      32'(pe_w && pe_wvalid));
      check("m1_r_en",      32'(m1_r_en),      32'(pe_r));
      if (ld_w && ld_wvalid) check("m0_w_addr", 32'(m0_w_addr), m_addr);
      if (ld_r)              check("m0_r_addr", 32'(m0_r_addr), m_addr);
      if (pe_w && pe_wvalid) check("m1_w_addr", 32'(m1_w_addr), m_addr);
      if (pe_r)              check("m1_r_addr", 32'(m1_r_addr), m_addr);
      model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_cmd_valid = 0; ld_cmd_wr = 0; ld_cmd_bank = '0; ld_cmd_addr = '0; ld_cmd_len = '0;
    ld_wvalid = 0;
    pe_cmd_valid = 0; pe_cmd_wr = 0; pe_cmd_addr = '0; pe_cmd_len = '0;
    pe_wvalid = 0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 40) begin
      tick();
      k++;
    end
    check({name, "_idle_timeout"}, 32'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pat[5];
    rst = 0;
    idle_inputs();
    model_reset();
    repeat (3) tick();
    check("hold_rst_ready", 32'(ld_cmd_ready), 0);
    rst = 1;
    #1;
    check("post_rst_ready", 32'(ld_cmd_ready), 1);
    tick();

    // Loader write, bank 3, 4 beats with one stall.
    clear_logs();
    ld_cmd_valid = 1; ld_cmd_wr = 1; ld_cmd_bank = 6'd3; ld_cmd_addr = 10'h010; ld_cmd_len = 8'd3;
    tick();
    ld_cmd_valid = 0;
    pat = '{1, 0, 1, 1, 1};
    foreach (pat[i]) begin
      ld_wvalid = pat[i][0];
      tick();
    end
    ld_wvalid = 0;
    tick();
    tick();
    check("ldw_beats", q_w0_en.size(), 4);
    for (int i = 0; i < q_w0_en.size() && i < 4; i++) begin
      check("ldw_en",   q_w0_en[i],   32'h0008);
      check("ldw_addr", q_w0_addr[i], 32'h010 + i);
    end
    check("ldw_done", n_done, 1);

    // PE read wrapping past the top of the address space.
    clear_logs();
    pe_cmd_valid = 1; pe_cmd_wr = 0; pe_cmd_addr = 10'h3FE; pe_cmd_len = 8'd2;
    tick();
    pe_cmd_valid = 0;
    repeat (5) tick();
    wait_idle("per");
    check("per_issues", q_r1_addr.size(), 3);
    check("per_rvalids", q_perv_cyc.size(), 3);
    if (q_r1_addr.size() == 3 && q_perv_cyc.size() == 3) begin
      check("per_addr0", q_r1_addr[0], 32'h3FE);
      check("per_addr1", q_r1_addr[1], 32'h3FF);
      check("per_addr2", q_r1_addr[2], 32'h000);
      for (int i = 0; i < 3; i++) check("per_lag", q_perv_cyc[i] - q_r1_cyc[i], 1);
      check("per_done_cnt", n_done, 1);
      if (n_done == 1) check("per_done_drain", q_done_cyc[0] - q_r1_cyc[2], 1);
    end

    // Simultaneous requests three times: loader, PE, loader.
    for (int g = 0; g < 3; g++) begin
      ld_cmd_valid = 1; ld_cmd_wr = 0; ld_cmd_bank = 6'd5; ld_cmd_addr = AW'(g); ld_cmd_len = 8'd0;
      pe_cmd_valid = 1; pe_cmd_wr = 0; pe_cmd_addr = AW'(g); pe_cmd_len = 8'd0;
      tick();
      ld_cmd_valid = 0; pe_cmd_valid = 0;
      check("rr_mode",  32'(mode),    (g == 1) ? 1 : 0);
      check("rr_pe",    32'(m1_r_en), (g == 1) ? 1 : 0);
      check("rr_ld",    32'(m0_r_en), (g == 1) ? 0 : 32'h0020);
      wait_idle("rr");
    end

    // Loader command naming a bank that does not exist.
    clear_logs();
    ld_cmd_valid = 1; ld_cmd_wr = 1; ld_cmd_bank = 6'd20; ld_cmd_addr = 10'h007; ld_cmd_len = 8'd3;
    tick();
    ld_cmd_valid = 0;
    check("bad_err",   32'(ld_err), 1);
    check("bad_busy",  32'(busy), 0);
    check("bad_ready", 32'(ld_cmd_ready), 1);
    tick();
    check("bad_err_pulse", 32'(ld_err), 0);
    tick();
    check("bad_err_cnt", n_err, 1);
    check("bad_no_en",   n_en_any, 0);
    check("bad_no_done", n_done, 0);

    // Reset in the middle of a PE write, then a normal burst.
    clear_logs();
    pe_cmd_valid = 1; pe_cmd_wr = 1; pe_cmd_addr = 10'h100; pe_cmd_len = 8'd4;
    tick();
    pe_cmd_valid = 0; pe_wvalid = 1;
    tick();
    tick();
    rst = 0;
    #1;
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_mode",  32'(mode), 0);
    check("mid_rst_w_en",  32'(m1_w_en), 0);
    check("mid_rst_wrdy",  32'(pe_wready), 0);
    check("mid_rst_done",  32'(done), 0);
    check("mid_rst_addr",  32'(m1_w_addr), 0);
    pe_wvalid = 0;
    tick();
    tick();
    rst = 1;
    tick();
    tick();
    check("mid_rst_beats", q_w1_addr.size(), 2);
    check("mid_rst_no_done", n_done, 0);
    clear_logs();
    pe_cmd_valid = 1; pe_cmd_wr = 1; pe_cmd_addr = 10'h020; pe_cmd_len = 8'd1;
    tick();
    pe_cmd_valid = 0; pe_wvalid = 1;
    tick();
    tick();
    pe_wvalid = 0;
    tick();
    check("post_rst_beats", q_w1_addr.size(), 2);
    if (q_w1_addr.size() == 2) begin
      check("post_rst_a0", q_w1_addr[0], 32'h020);
      check("post_rst_a1", q_w1_addr[1], 32'h021);
    end
    check("post_rst_done", n_done, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 299) != 0);
      ld_cmd_valid = ($urandom_range(0, 2) == 0);
      ld_cmd_wr    = 1'($urandom_range(0, 1));
      ld_cmd_bank  = ($urandom_range(0, 9) == 0) ? BW'($urandom_range(16, 63))
                                                 : BW'($urandom_range(0, 15));
      ld_cmd_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(1020, 1023))
                                                 : AW'($urandom_range(0, 1023));
      ld_cmd_len   = 8'($urandom_range(0, 6));
      ld_wvalid    = ($urandom_range(0, 9) < 7);
      pe_cmd_valid = ($urandom_range(0, 2) == 0);
      pe_cmd_wr    = 1'($urandom_range(0, 1));
      pe_cmd_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(1020, 1023))
                                                 : AW'($urandom_range(0, 1023));
      pe_cmd_len   = 8'($urandom_range(0, 6));
      pe_wvalid    = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst = 1;
    idle_inputs();
    ld_wvalid = 1; pe_wvalid = 1;
    tick();
    wait_idle("final");
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/membuf_sched.md
MEMBUF_SCHED -- requirements
Module: membuf_sched

Interface
REQ-001 Parameter N_PE, default 16, number of memory banks and PE lanes.
REQ-002 Parameter ADDR_RAM, default 10, bank address width.
REQ-003 Parameter BANK_W, default 6, loader bank-index width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (rst=0 resets).
REQ-006 ld_cmd_valid / ld_cmd_ready  input / output  1 / 1  loader command handshake.
REQ-007 ld_cmd_wr, ld_cmd_bank, ld_cmd_addr, ld_cmd_len  input  1, BANK_W, ADDR_RAM, 8  loader direction (1=write), bank index, start address, beats-1.
REQ-008 ld_wvalid / ld_wready  input / output  1 / 1  loader write-beat handshake.
REQ-009 ld_rvalid, ld_err  output  1, 1  loader read-data valid; bad-bank pulse.
REQ-010 pe_cmd_valid / pe_cmd_ready  input / output  1 / 1  PE-array command handshake.
REQ-011 pe_cmd_wr, pe_cmd_addr, pe_cmd_len  input  1, ADDR_RAM, 8  PE direction, start address, beats-1.
REQ-012 pe_wvalid / pe_wready, pe_rvalid  input / output, output  1 / 1, 1  PE write-beat handshake; read-data valid.
REQ-013 mode  output  1  buffer mode: 0=loader single-bank path, 1=PE broadcast path.
REQ-014 m0_r_en, m0_w_en  output  N_PE each  one-hot loader bank read/write enables.
REQ-015 m0_r_addr, m0_w_addr, m1_r_addr, m1_w_addr  output  ADDR_RAM each  bank addresses.
REQ-016 m1_r_en, m1_w_en  output  1 each  broadcast read/write enables.
REQ-017 busy, done  output  1, 1  burst in progress; one-cycle pulse at burst end.

Function
REQ-018 States: IDLE, LD_WR, LD_RD, PE_WR, PE_RD, DRAIN.
REQ-019 ld_cmd_ready/pe_cmd_ready high only in IDLE; at most one command accepted per cycle.
REQ-020 Both valid in IDLE: grant round-robin pointer; grant toggles pointer to the other requester; single valid always granted.
REQ-021 On accept: register bank, address, beat counter = len+1; mode set registered (0 for loader, 1 for PE) in the same edge; mode SHALL change only on accept from IDLE.
REQ-022 Loader command with ld_cmd_bank >= N_PE: accepted, ld_err pulses 1 cycle next cycle, no enables, stays IDLE, no done.
REQ-023 Write states: wready=1 for the active requester; a beat issues on each cycle wvalid=1, asserting w_en (m0_w_en one-hot or m1_w_en) combinationally with w_addr = current address; address and counter advance on that edge.
REQ-024 Read states: r_en asserted every cycle with r_addr = current address, advancing each cycle; rvalid registered, high exactly 1 cycle after each r_en (bank read latency 1).
REQ-025 Address increments modulo 2^ADDR_RAM (wraps max->0 within a burst).
REQ-026 Last write beat -> IDLE with done=1 next cycle; last read issue -> DRAIN for 1 cycle (mode held, last rvalid high) -> IDLE; done=1 in the DRAIN cycle.
REQ-027 Enables never asserted outside their state; m0_* enables all-zero whenever mode=1, m1_* zero whenever mode=0.
REQ-028 busy=1 in every state except IDLE.
REQ-029 Write-beat stalls (wvalid=0) hold address and counter; no timeout.

Reset
REQ-030 rst=0 asynchronously forces IDLE, mode=0, all enables/readys/valids/done/err/busy 0, addresses 0, counter 0, RR pointer to loader; in-flight bursts abandoned, no done.
REQ-031 After rst release, first command accepted no earlier than the first rising edge with rst=1.

Verification
REQ-032 Loader write bank 3, addr 0x010, len 3, wvalid gapped 1-0-1-1-1 -> m0_w_en=0x0008 on 4 beats, addrs 0x010..0x013, done once.
REQ-033 PE read addr 0x3FE, len 2 -> m1_r_addr 0x3FE,0x3FF,0x000; pe_rvalid 3 cycles lagging by 1; DRAIN then done.
REQ-034 Both cmd_valid in IDLE three times -> grants loader, PE, loader; mode 0,1,0.
REQ-035 Loader cmd bank 20 (N_PE=16) -> ld_err pulse, no enables, state IDLE.
REQ-036 rst=0 mid PE write after 2 of 5 beats -> outputs zero immediately, mode=0, no done; next command runs normally.
